// File: rtl/riscv_core_result_buffer.sv
// Result buffer between the two execution pipes and the ROB / register file.
// Latency: completion -> ROB request and retire -> RF write are 1 cycle; operand bypass is combinational.
// Backpressure: none; every completion and retire is accepted on the cycle it is presented.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpl_val/slot/data_A/B           completions from execution pipes A and B
//   ROB_commit_req(_slot)_A/B       registered mark-finished requests to the ROB
//   ROB_commit_ready/wen/slot/rdaddr_A/B  retire information from the ROB (A older than B)
//   rf_wen/waddr/wdata_A/B          registered architectural register-file writes
//   byp_slot_k/byp_done_k/byp_data_k  operand lookup by ROB slot (k = 0..3)
//   rb_count                        number of slots currently holding a done result
module riscv_core_result_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpl_val_A,
    input  logic              cpl_val_B,
    input  logic [4:0]        cpl_slot_A,
    input  logic [4:0]        cpl_slot_B,
    input  logic [DATA_W-1:0] cpl_data_A,
    input  logic [DATA_W-1:0] cpl_data_B,
    output logic              ROB_commit_req_A,
    output logic              ROB_commit_req_B,
    output logic [4:0]        ROB_commit_req_slot_A,
    output logic [4:0]        ROB_commit_req_slot_B,
    input  logic              ROB_commit_ready_A,
    input  logic              ROB_commit_ready_B,
    input  logic              ROB_commit_wen_A,
    input  logic              ROB_commit_wen_B,
    input  logic [4:0]        ROB_commit_slot_A,
    input  logic [4:0]        ROB_commit_slot_B,
    input  logic [4:0]        ROB_commit_rdaddr_A,
    input  logic [4:0]        ROB_commit_rdaddr_B,
    output logic              rf_wen_A,
    output logic              rf_wen_B,
    output logic [4:0]        rf_waddr_A,
    output logic [4:0]        rf_waddr_B,
    output logic [DATA_W-1:0] rf_wdata_A,
    output logic [DATA_W-1:0] rf_wdata_B,
    input  logic [4:0]        byp_slot_0,
    input  logic [4:0]        byp_slot_1,
    input  logic [4:0]        byp_slot_2,
    input  logic [4:0]        byp_slot_3,
    output logic              byp_done_0,
    output logic              byp_done_1,
    output logic              byp_done_2,
    output logic              byp_done_3,
    output logic [DATA_W-1:0] byp_data_0,
    output logic [DATA_W-1:0] byp_data_1,
    output logic [DATA_W-1:0] byp_data_2,
    output logic [DATA_W-1:0] byp_data_3,
    output logic [5:0]        rb_count
);

    localparam int N = 32;

    logic [N-1:0]      done_q, done_d;
    logic [DATA_W-1:0] data_q [N];
    logic [DATA_W-1:0] data_d [N];
    logic [5:0]        count_q, count_d;

    logic              req_a_q, req_a_d, req_b_q, req_b_d;
    logic [4:0]        req_slot_a_q, req_slot_a_d, req_slot_b_q, req_slot_b_d;

    logic              rf_wen_a_q, rf_wen_a_d, rf_wen_b_q, rf_wen_b_d;
    logic [4:0]        rf_waddr_a_q, rf_waddr_a_d, rf_waddr_b_q, rf_waddr_b_d;
    logic [DATA_W-1:0] rf_wdata_a_q, rf_wdata_a_d, rf_wdata_b_q, rf_wdata_b_d;

    logic              cpl_a_eff;
    logic              wr_a, wr_b;
    logic [N-1:0]      set_mask, clr_mask;

    logic [4:0]        bp_slot [4];
    logic [3:0]        bp_done;
    logic [DATA_W-1:0] bp_data [4];

    function automatic logic [5:0] popcnt(input logic [N-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // When both pipes complete into the same slot, B is the survivor; A is dropped
    // entirely so done is set once and only B raises a ROB request.
    assign cpl_a_eff = cpl_val_A && !(cpl_val_B && (cpl_slot_A == cpl_slot_B));

    assign wr_a = ROB_commit_ready_A && ROB_commit_wen_A && (ROB_commit_rdaddr_A != 5'd0);
    assign wr_b = ROB_commit_ready_B && ROB_commit_wen_B && (ROB_commit_rdaddr_B != 5'd0);

    always_comb begin
        done_d = done_q;
        data_d = data_q;
        // Retire clears first so a same-cycle completion to that slot wins.
        if (ROB_commit_ready_A) done_d[ROB_commit_slot_A] = 1'b0;
        if (ROB_commit_ready_B) done_d[ROB_commit_slot_B] = 1'b0;
        if (cpl_a_eff) begin
            done_d[cpl_slot_A] = 1'b1;
            data_d[cpl_slot_A] = cpl_data_A;
        end
        if (cpl_val_B) begin
            done_d[cpl_slot_B] = 1'b1;
            data_d[cpl_slot_B] = cpl_data_B;
        end
        // Counting only real 0->1 and 1->0 transitions removes any double counting
        // from duplicate retires or retire/complete overlap. The 6-bit arithmetic
        // is exact because the true result always lies in 0..32.
        set_mask = done_d & ~done_q;
        clr_mask = done_q & ~done_d;
        count_d  = count_q + popcnt(set_mask) - popcnt(clr_mask);
    end

    always_comb begin
        req_a_d      = cpl_a_eff;
        req_slot_a_d = cpl_a_eff ? cpl_slot_A : 5'd0;
        req_b_d      = cpl_val_B;
        req_slot_b_d = cpl_val_B ? cpl_slot_B : 5'd0;

        rf_wen_a_d   = wr_a;
        rf_waddr_a_d = wr_a ? ROB_commit_rdaddr_A : 5'd0;
        rf_wdata_a_d = wr_a ? data_q[ROB_commit_slot_A] : '0;
        rf_wen_b_d   = wr_b;
        rf_waddr_b_d = wr_b ? ROB_commit_rdaddr_B : 5'd0;
        rf_wdata_b_d = wr_b ? data_q[ROB_commit_slot_B] : '0;
    end

    assign bp_slot[0] = byp_slot_0;
    assign bp_slot[1] = byp_slot_1;
    assign bp_slot[2] = byp_slot_2;
    assign bp_slot[3] = byp_slot_3;

    // Bypass forwards this cycle's completions (B over A); stale data of a
    // slot that is not done is masked to zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bp_done[k] = 1'b0;
            bp_data[k] = '0;
            if (cpl_val_B && (cpl_slot_B == bp_slot[k])) begin
                bp_done[k] = 1'b1;
                bp_data[k] = cpl_data_B;
            end else if (cpl_val_A && (cpl_slot_A == bp_slot[k])) begin
                bp_done[k] = 1'b1;
                bp_data[k] = cpl_data_A;
            end else if (done_q[bp_slot[k]]) begin
                bp_done[k] = 1'b1;
                bp_data[k] = data_q[bp_slot[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q       <= '0;
            count_q      <= '0;
            req_a_q      <= 1'b0;
            req_b_q      <= 1'b0;
            req_slot_a_q <= '0;
            req_slot_b_q <= '0;
            rf_wen_a_q   <= 1'b0;
            rf_wen_b_q   <= 1'b0;
            rf_waddr_a_q <= '0;
            rf_waddr_b_q <= '0;
            rf_wdata_a_q <= '0;
            rf_wdata_b_q <= '0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            done_q       <= done_d;
            count_q      <= count_d;
            req_a_q      <= req_a_d;
            req_b_q      <= req_b_d;
            req_slot_a_q <= req_slot_a_d;
            req_slot_b_q <= req_slot_b_d;
            rf_wen_a_q   <= rf_wen_a_d;
            rf_wen_b_q   <= rf_wen_b_d;
            rf_waddr_a_q <= rf_waddr_a_d;
            rf_waddr_b_q <= rf_waddr_b_d;
            rf_wdata_a_q <= rf_wdata_a_d;
            rf_wdata_b_q <= rf_wdata_b_d;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign ROB_commit_req_A      = req_a_q;
    assign ROB_commit_req_B      = req_b_q;
    assign ROB_commit_req_slot_A = req_slot_a_q;
    assign ROB_commit_req_slot_B = req_slot_b_q;
    assign rf_wen_A              = rf_wen_a_q;
    assign rf_wen_B              = rf_wen_b_q;
    assign rf_waddr_A            = rf_waddr_a_q;
    assign rf_waddr_B            = rf_waddr_b_q;
    assign rf_wdata_A            = rf_wdata_a_q;
    assign rf_wdata_B            = rf_wdata_b_q;
    assign rb_count              = count_q;

    assign byp_done_0 = bp_done[0];
    assign byp_done_1 = bp_done[1];
    assign byp_done_2 = bp_done[2];
    assign byp_done_3 = bp_done[3];
    assign byp_data_0 = bp_data[0];
    assign byp_data_1 = bp_data[1];
    assign byp_data_2 = bp_data[2];
    assign byp_data_3 = bp_data[3];

endmodule

// File: tb/tb_riscv_core_result_buffer.sv
// Scoreboard bench for the result buffer: a behavioural model predicts registered
// outputs per cycle (queued at drive time, compared after the edge) and the
// combinational bypass before the edge.
module tb_riscv_core_result_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        va, vb;
    logic [4:0]  sa, sb;
    logic [31:0] da, db;
    logic        rdy_a, rdy_b, wen_a, wen_b;
    logic [4:0]  cs_a, cs_b, rd_a, rd_b;
    logic [4:0]  bs [4];

    logic        req_a, req_b;
    logic [4:0]  rsa, rsb;
    logic        rfw_a, rfw_b;
    logic [4:0]  rfa_a, rfa_b;
    logic [31:0] rfd_a, rfd_b;
    logic [3:0]  bd;
    logic [31:0] bdat [4];
    logic [5:0]  cnt;

    riscv_core_result_buffer #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpl_val_A(va), .cpl_val_B(vb),
        .cpl_slot_A(sa), .cpl_slot_B(sb),
        .cpl_data_A(da), .cpl_data_B(db),
        .ROB_commit_req_A(req_a), .ROB_commit_req_B(req_b),
        .ROB_commit_req_slot_A(rsa), .ROB_commit_req_slot_B(rsb),
        .ROB_commit_ready_A(rdy_a), .ROB_commit_ready_B(rdy_b),
        .ROB_commit_wen_A(wen_a), .ROB_commit_wen_B(wen_b),
        .ROB_commit_slot_A(cs_a), .ROB_commit_slot_B(cs_b),
        .ROB_commit_rdaddr_A(rd_a), .ROB_commit_rdaddr_B(rd_b),
        .rf_wen_A(rfw_a), .rf_wen_B(rfw_b),
        .rf_waddr_A(rfa_a), .rf_waddr_B(rfa_b),
        .rf_wdata_A(rfd_a), .rf_wdata_B(rfd_b),
        .byp_slot_0(bs[0]), .byp_slot_1(bs[1]), .byp_slot_2(bs[2]), .byp_slot_3(bs[3]),
        .byp_done_0(bd[0]), .byp_done_1(bd[1]), .byp_done_2(bd[2]), .byp_done_3(bd[3]),
        .byp_data_0(bdat[0]), .byp_data_1(bdat[1]), .byp_data_2(bdat[2]), .byp_data_3(bdat[3]),
        .rb_count(cnt)
    );

    typedef struct {
        logic        req_a, req_b;
        logic [4:0]  rs_a, rs_b;
        logic        rfw_a, rfw_b;
        logic [4:0]  rfa_a, rfa_b;
        logic [31:0] rfd_a, rfd_b;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_done;
    logic [31:0] m_data [32];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        va = 0; vb = 0; sa = 0; sb = 0; da = 0; db = 0;
        rdy_a = 0; rdy_b = 0; wen_a = 0; wen_b = 0;
        cs_a = 0; cs_b = 0; rd_a = 0; rd_b = 0;
        for (int k = 0; k < 4; k++) bs[k] = 0;
    endtask

    task automatic cpl(input bit port, input logic [4:0] s, input logic [31:0] d);
        if (!port) begin va = 1; sa = s; da = d; end
        else       begin vb = 1; sb = s; db = d; end
    endtask

    task automatic ret(input bit port, input logic [4:0] s, input logic w, input logic [4:0] rd);
        if (!port) begin rdy_a = 1; cs_a = s; wen_a = w; rd_a = rd; end
        else       begin rdy_b = 1; cs_b = s; wen_b = w; rd_b = rd; end
    endtask

    // One clock: check bypass against the pre-edge model, queue the expected
    // registered outputs, advance the model, then compare after the edge.
    task automatic cycle();
        exp_t        e, o;
        logic        ex_d, a_eff;
        logic [31:0] ex_v;
        #1;
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                ex_d = m_done[bs[k]];
                ex_v = m_done[bs[k]] ? m_data[bs[k]] : 32'd0;
                if (va && sa == bs[k]) begin ex_d = 1; ex_v = da; end
                if (vb && sb == bs[k]) begin ex_d = 1; ex_v = db; end
                check($sformatf("byp_done%0d", k), {63'd0, bd[k]}, {63'd0, ex_d});
                check($sformatf("byp_data%0d", k), {32'd0, bdat[k]}, {32'd0, ex_v});
            end
        end
        e = '{default: '0};
        if (reset) begin
            m_done = 0;
            for (int i = 0; i < 32; i++) m_data[i] = 0;
        end else begin
            a_eff   = va && !(vb && sa == sb);
            e.req_a = a_eff;  e.rs_a = a_eff ? sa : 5'd0;
            e.req_b = vb;     e.rs_b = vb ? sb : 5'd0;
            if (rdy_a && wen_a && rd_a != 0) begin e.rfw_a = 1; e.rfa_a = rd_a; e.rfd_a = m_data[cs_a]; end
            if (rdy_b && wen_b && rd_b != 0) begin e.rfw_b = 1; e.rfa_b = rd_b; e.rfd_b = m_data[cs_b]; end
            if (rdy_a) m_done[cs_a] = 0;
            if (rdy_b) m_done[cs_b] = 0;
            if (a_eff) begin m_done[sa] = 1; m_data[sa] = da; end
            if (vb)    begin m_done[sb] = 1; m_data[sb] = db; end
        end
        e.cnt = 6'($countones(m_done));
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        o = sb_q.pop_front();
        check("req_a",   {63'd0, req_a}, {63'd0, o.req_a});
        check("rslot_a", {59'd0, rsa},   {59'd0, o.rs_a});
        check("req_b",   {63'd0, req_b}, {63'd0, o.req_b});
        check("rslot_b", {59'd0, rsb},   {59'd0, o.rs_b});
        check("rfw_a",   {63'd0, rfw_a}, {63'd0, o.rfw_a});
        check("rfa_a",   {59'd0, rfa_a}, {59'd0, o.rfa_a});
        check("rfd_a",   {32'd0, rfd_a}, {32'd0, o.rfd_a});
        check("rfw_b",   {63'd0, rfw_b}, {63'd0, o.rfw_b});
        check("rfa_b",   {59'd0, rfa_b}, {59'd0, o.rfa_b});
        check("rfd_b",   {32'd0, rfd_b}, {32'd0, o.rfd_b});
        check("rb_count",{58'd0, cnt},   {58'd0, o.cnt});
        idle_inputs();
    endtask

    initial begin
        m_done = 0;
        for (int i = 0; i < 32; i++) m_data[i] = 0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;

        // Completion on A, slot 3.
        cpl(0, 5'd3, 32'hDEADBEEF);
        cycle();
        check("c28_req_a", {63'd0, req_a}, 64'd1);
        check("c28_slot",  {59'd0, rsa},   64'd3);
        check("c28_count", {58'd0, cnt},   64'd1);
        bs[0] = 5'd3;
        #1 check("c28_byp", {63'd0, bd[0]}, 64'd1);
        cycle();

        // Retire slot 3 to x5.
        ret(0, 5'd3, 1'b1, 5'd5);
        cycle();
        check("c29_wen",   {63'd0, rfw_a}, 64'd1);
        check("c29_waddr", {59'd0, rfa_a}, 64'd5);
        check("c29_wdata", {32'd0, rfd_a}, 64'hDEADBEEF);
        check("c29_count", {58'd0, cnt},   64'd0);
        bs[2] = 5'd3;
        #1 check("c29_done3", {63'd0, bd[2]}, 64'd0);
        cycle();

        // Retire to x0 and retire without write enable.
        cpl(0, 5'd4, 32'h1111);
        cpl(1, 5'd6, 32'h2222);
        cycle();
        ret(0, 5'd4, 1'b1, 5'd0);
        ret(1, 5'd6, 1'b0, 5'd9);
        cycle();
        check("c30_wen_a", {63'd0, rfw_a}, 64'd0);
        check("c30_wen_b", {63'd0, rfw_b}, 64'd0);
        check("c30_count", {58'd0, cnt},   64'd0);

        // Both pipes to slot 7: B wins.
        cpl(0, 5'd7, 32'd1);
        cpl(1, 5'd7, 32'd2);
        cycle();
        check("c31_req_a", {63'd0, req_a}, 64'd0);
        check("c31_req_b", {63'd0, req_b}, 64'd1);
        check("c31_count", {58'd0, cnt},   64'd1);
        bs[1] = 5'd7;
        #1 check("c31_data7", {32'd0, bdat[1]}, 64'd2);
        cycle();

        // Same-cycle bypass from B.
        bs[0] = 5'd9;
        cpl(1, 5'd9, 32'h55);
        #1;
        check("c32_done", {63'd0, bd[0]}, 64'd1);
        check("c32_data", {32'd0, bdat[0]}, 64'h55);
        cycle();

        // Completion overrides a same-cycle retire of the same slot, then dual retire.
        ret(0, 5'd7, 1'b1, 5'd10);
        cpl(0, 5'd7, 32'hAAAA);
        cycle();
        ret(0, 5'd7, 1'b1, 5'd10);
        ret(1, 5'd9, 1'b1, 5'd11);
        cycle();

        // Random traffic on a small slot range to force collisions.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1)) cpl(0, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1)) cpl(1, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) ret(0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) ret(1, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
            for (int k = 0; k < 4; k++) bs[k] = 5'($urandom_range(0, 7));
            cycle();
        end

        // Wrap-around slots, then reset with a completion that must be dropped.
        cpl(0, 5'd30, 32'h30);
        cpl(1, 5'd31, 32'h31);
        cycle();
        cpl(0, 5'd0, 32'h00C0FFEE);
        bs[3] = 5'd31;
        cycle();
        reset = 1;
        cpl(1, 5'd5, 32'h5);
        ret(0, 5'd30, 1'b1, 5'd4);
        cycle();
        reset = 0;
        check("c33_count", {58'd0, cnt}, 64'd0);
        check("c33_req_b", {63'd0, req_b}, 64'd0);
        check("c33_rfw_a", {63'd0, rfw_a}, 64'd0);
        for (int s = 0; s < 32; s++) begin
            bs[0] = 5'(s);
            #1 check($sformatf("c33_byp%0d", s), {63'd0, bd[0]}, 64'd0);
        end
        cycle();
        cpl(0, 5'd12, 32'h12);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
